// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates an instruction-fetch port and a data port onto one single-port RAM.
// Latency: grant on the edge after the request; ready pulses the cycle after the first edge that samples ram_busy=0.
// Backpressure: ram_busy stalls the granted side; a timeout counter aborts stuck transactions and sets sticky mem_err.
//
// Ports:
//   CLK, nRST               clock, synchronous active-low reset
//   iren, iaddr             fetch request / address
//   i_ready, iload          fetch-done pulse / fetched word
//   dren, dwen, daddr,      data read / write request, address,
//   dstore                  write data
//   d_ready, dload          data-done pulse / loaded word
//   ram_ren, ram_wen,       shared memory strobes,
//   ram_addr, ram_store,    latched address / write data,
//   ram_load, ram_busy      read data / stall
//   mem_err                 sticky timeout flag
module memory_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iren,
  input  logic [31:0] iaddr,
  output logic        i_ready,
  output logic [31:0] iload,
  input  logic        dren,
  input  logic        dwen,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        d_ready,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_busy,
  output logic        mem_err
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [7:0] TO_LIM   = 8'(TIMEOUT_CYC);
  localparam logic       LG_FETCH = 1'b0;
  localparam logic       LG_DATA  = 1'b1;

  state_t      state_q;
  logic        last_grant_q;
  logic [7:0]  cnt_q;

  logic        i_pend;
  logic        d_pend;
  logic        grant_d;
  logic        grant_i;
  logic [7:0]  cnt_d;
  logic        timeout;

  always_comb begin
    // A requester whose ready is high this cycle is still showing the
    // request that just completed, so it must not be re-issued.
    i_pend  = iren & ~i_ready;
    d_pend  = (dren | dwen) & ~d_ready;
    // Data has priority unless it took the previous grant.
    grant_d = d_pend & (~i_pend | (last_grant_q == LG_FETCH));
    grant_i = i_pend & ~grant_d;
    // Saturating busy counter; abort on the edge it reaches the limit.
    cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    timeout = ram_busy & (cnt_d >= TO_LIM);
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= IDLE;
      last_grant_q <= LG_FETCH;
      cnt_q        <= '0;
      ram_ren      <= 1'b0;
      ram_wen      <= 1'b0;
      ram_addr     <= '0;
      ram_store    <= '0;
      i_ready      <= 1'b0;
      d_ready      <= 1'b0;
      iload        <= '0;
      dload        <= '0;
      mem_err      <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q      <= DGNT;
            last_grant_q <= LG_DATA;
            cnt_q        <= '0;
            ram_addr     <= daddr;
            ram_store    <= dstore;
            // dren together with dwen is a write.
            ram_wen      <= dwen;
            ram_ren      <= ~dwen;
          end else if (grant_i) begin
            state_q      <= IGNT;
            last_grant_q <= LG_FETCH;
            cnt_q        <= '0;
            ram_addr     <= iaddr;
            ram_ren      <= 1'b1;
            ram_wen      <= 1'b0;
          end
        end
        IGNT, DGNT: begin
          if (!ram_busy || timeout) begin
            state_q <= IDLE;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            if (state_q == IGNT) begin
              i_ready <= 1'b1;
              iload   <= ram_busy ? 32'h0000_0000 : ram_load;
            end else begin
              d_ready <= 1'b1;
              // Aborted transactions return zero; completed writes leave dload alone.
              if (ram_busy) begin
                dload <= 32'h0000_0000;
              end else if (!ram_wen) begin
                dload <= ram_load;
              end
            end
            if (ram_busy) begin
              mem_err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench with a transaction-level reference model for memory_arbiter.
// Inputs change 1 time unit after each rising edge; outputs are compared on falling edges.
// Run uses TIMEOUT_CYC=4 so the abort path is reached in a few cycles.
module tb_memory_arbiter;

  localparam int TO = 4;

  logic        CLK;
  logic        nRST;
  logic        iren;
  logic [31:0] iaddr;
  logic        i_ready;
  logic [31:0] iload;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        d_ready;
  logic [31:0] dload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_busy;
  logic        mem_err;

  memory_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .iren      (iren),
    .iaddr     (iaddr),
    .i_ready   (i_ready),
    .iload     (iload),
    .dren      (dren),
    .dwen      (dwen),
    .daddr     (daddr),
    .dstore    (dstore),
    .d_ready   (d_ready),
    .dload     (dload),
    .ram_ren   (ram_ren),
    .ram_wen   (ram_wen),
    .ram_addr  (ram_addr),
    .ram_store (ram_store),
    .ram_load  (ram_load),
    .ram_busy  (ram_busy),
    .mem_err   (mem_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model: tracks one in-flight transaction and what each output must be.
  bit          model_ok = 0;
  bit          m_active, m_is_data, m_is_write, m_last_data;
  int          m_busy_n;
  logic        m_ren, m_wen, m_ir, m_dr, m_err;
  logic [31:0] m_addr, m_store, m_iload, m_dload;
  bit          was_ir, was_dr, want_i, want_d, take_d, aborted;

  always @(posedge CLK) begin
    cyc++;
    if (!nRST) begin
      model_ok = 1; m_active = 0; m_last_data = 0; m_busy_n = 0;
      m_ren = 0; m_wen = 0; m_ir = 0; m_dr = 0; m_err = 0;
      m_addr = 0; m_store = 0; m_iload = 0; m_dload = 0;
    end else begin
      was_ir = m_ir;
      was_dr = m_dr;
      m_ir = 0;
      m_dr = 0;
      if (!m_active) begin
        want_i = iren && !was_ir;
        want_d = (dren || dwen) && !was_dr;
        if (want_i || want_d) begin
          take_d      = want_d && !(want_i && m_last_data);
          m_active    = 1;
          m_is_data   = take_d;
          m_last_data = take_d;
          m_busy_n    = 0;
          if (take_d) begin
            m_addr = daddr; m_store = dstore; m_is_write = dwen;
            m_wen = dwen; m_ren = !dwen;
          end else begin
            m_addr = iaddr; m_is_write = 0; m_ren = 1; m_wen = 0;
          end
        end
      end else begin
        if (ram_busy) m_busy_n++;
        if (!ram_busy || m_busy_n >= TO) begin
          aborted  = ram_busy;
          m_active = 0; m_ren = 0; m_wen = 0;
          if (aborted) m_err = 1;
          if (m_is_data) begin
            m_dr = 1;
            if (aborted) m_dload = 0;
            else if (!m_is_write) m_dload = ram_load;
          end else begin
            m_ir = 1;
            m_iload = aborted ? 32'h0 : ram_load;
          end
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (model_ok) begin
      chk("ram_ren",   ram_ren,   m_ren);
      chk("ram_wen",   ram_wen,   m_wen);
      chk("ram_addr",  ram_addr,  m_addr);
      chk("ram_store", ram_store, m_store);
      chk("i_ready",   i_ready,   m_ir);
      chk("d_ready",   d_ready,   m_dr);
      chk("iload",     iload,     m_iload);
      chk("dload",     dload,     m_dload);
      chk("mem_err",   mem_err,   m_err);
      chk("rdy_excl",  i_ready & d_ready, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] seqv;
  int          pulses;

  initial begin
    iren = 0; iaddr = 0; dren = 0; dwen = 0; daddr = 0; dstore = 0;
    ram_load = 0; ram_busy = 0; nRST = 0;
    tick(); tick();
    chk("h_rst_ren",   ram_ren,  0);
    chk("h_rst_addr",  ram_addr, 0);
    chk("h_rst_err",   mem_err,  0);
    chk("h_rst_iload", iload,    0);
    nRST = 1;

    // Single fetch, memory ready immediately.
    iren = 1; iaddr = 32'h100; ram_load = 32'h0050_0093;
    tick();
    chk("h_f_ren",  ram_ren,  1);
    chk("h_f_addr", ram_addr, 32'h100);
    chk("h_f_rdy0", i_ready,  0);
    iren = 0; iaddr = 32'hFFFF_FFFF;
    tick();
    chk("h_f_rdy",   i_ready, 1);
    chk("h_f_iload", iload,   32'h0050_0093);
    chk("h_f_ren0",  ram_ren, 0);
    tick();
    chk("h_f_pulse", i_ready, 0);

    // Contention from reset: expect D,I,D,I (D=4'hD, I=4'h1).
    nRST = 0; tick(); nRST = 1;
    iren = 1; dren = 1; iaddr = 32'h200; daddr = 32'h300; ram_load = 32'h11;
    seqv = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (d_ready) seqv = {seqv[27:0], 4'hD};
      if (i_ready) seqv = {seqv[27:0], 4'h1};
    end
    chk("h_alt_seq", seqv,  32'h0000_D1D1);
    chk("h_alt_dld", dload, 32'h11);
    iren = 0; dren = 0;
    tick(); tick();

    // dren and dwen together is a write; dload keeps its old value.
    dren = 1; dwen = 1; daddr = 32'h40; dstore = 32'h55; ram_load = 32'h66;
    tick();
    chk("h_rw_wen", ram_wen, 1);
    chk("h_rw_ren", ram_ren, 0);
    dren = 0; dwen = 0;
    tick();
    chk("h_rw_rdy", d_ready, 1);
    chk("h_rw_dld", dload,   32'h11);
    tick();

    // Store stalled for three busy cycles; inputs change underneath it.
    dwen = 1; daddr = 32'h2000; dstore = 32'hDEAD_BEEF; ram_busy = 1;
    tick();
    dwen = 0; daddr = 32'h0; dstore = 32'h0;
    for (int k = 0; k < 4; k++) begin
      chk("h_st_wen",  ram_wen,   1);
      chk("h_st_addr", ram_addr,  32'h2000);
      chk("h_st_dat",  ram_store, 32'hDEAD_BEEF);
      if (k == 3) ram_busy = 0;
      tick();
    end
    chk("h_st_rdy",  d_ready, 1);
    chk("h_st_dld",  dload,   32'h11);
    chk("h_st_wen0", ram_wen, 0);
    chk("h_st_err",  mem_err, 0);
    tick();
    chk("h_st_pulse", d_ready, 0);

    // Data read with memory stuck busy: abort after four busy edges.
    dren = 1; daddr = 32'h500; ram_busy = 1; ram_load = 32'h99;
    tick();
    dren = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("h_to_ren",  ram_ren, 1);
      chk("h_to_rdy0", d_ready, 0);
    end
    tick();
    chk("h_to_rdy",  d_ready, 1);
    chk("h_to_dld",  dload,   0);
    chk("h_to_err",  mem_err, 1);
    chk("h_to_ren0", ram_ren, 0);
    ram_busy = 0;
    tick();

    // Arbitration continues normally with mem_err set.
    iren = 1; iaddr = 32'h600; ram_load = 32'hCAFE_F00D;
    tick();
    iren = 0;
    tick();
    chk("h_pe_rdy",   i_ready, 1);
    chk("h_pe_iload", iload,   32'hCAFE_F00D);
    chk("h_pe_err",   mem_err, 1);
    tick();

    // Fetch timeout returns zero.
    iren = 1; iaddr = 32'h680; ram_busy = 1;
    tick();
    iren = 0;
    tick(); tick(); tick(); tick();
    chk("h_fto_rdy",   i_ready, 1);
    chk("h_fto_iload", iload,   0);
    ram_busy = 0;
    tick();

    // Reset while a fetch is stalled.
    iren = 1; iaddr = 32'h800; ram_busy = 1;
    tick();
    chk("h_rm_ren", ram_ren, 1);
    nRST = 0;
    tick();
    chk("h_rm_ren0",  ram_ren,  0);
    chk("h_rm_addr",  ram_addr, 0);
    chk("h_rm_rdy",   i_ready,  0);
    chk("h_rm_iload", iload,    0);
    chk("h_rm_err",   mem_err,  0);
    nRST = 1; iren = 0; ram_busy = 0;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (i_ready) pulses++;
    end
    chk("h_rm_nopulse", pulses, 0);

    // Fetch request held across completion.
    iren = 1; iaddr = 32'h700; ram_load = 32'h77;
    tick();
    chk("h_hd_ren1", ram_ren, 1);
    tick();
    chk("h_hd_rdy",   i_ready, 1);
    chk("h_hd_iload", iload,   32'h77);
    chk("h_hd_ren0",  ram_ren, 0);
    tick();
    chk("h_hd_noiss", ram_ren, 0);
    chk("h_hd_rdy0",  i_ready, 0);
    tick();
    chk("h_hd_ren2", ram_ren,  1);
    chk("h_hd_addr", ram_addr, 32'h700);
    iren = 0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
